// File: rtl/write_iq.sv
// Output serializer: pops paired I/Q fixed-point samples, dequantizes and saturates them to
// signed 16-bit, and writes little-endian bytes I_lo, I_hi, Q_lo, Q_hi into a byte FIFO.
module write_iq #(
    parameter int DATA_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter int CHAR_SIZE = 16,
    parameter int BITS      = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_in_empty,
    output logic                 i_in_rd_en,
    input  logic [DATA_SIZE-1:0] i_in_dout,
    input  logic                 q_in_empty,
    output logic                 q_in_rd_en,
    input  logic [DATA_SIZE-1:0] q_in_dout,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [BYTE_SIZE-1:0] out_din,
    output logic [31:0]          pair_count,
    output logic [15:0]          sat_count,
    output logic [0:0]           fsm_state
);

    // Handshake: a FIFO pop happens on a clock edge where *_rd_en is high and the
    // FIFO is non-empty; a byte is accepted on an edge where out_wr_en is high, which
    // is only ever raised while out_full is low.

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    localparam logic signed [DATA_SIZE-1:0] SAT_MAX = DATA_SIZE'((1 << (CHAR_SIZE - 1)) - 1);
    localparam logic signed [DATA_SIZE-1:0] SAT_MIN = DATA_SIZE'(-(1 << (CHAR_SIZE - 1)));

    logic [0:0]              state;
    logic [1:0]              idx;
    logic [CHAR_SIZE-1:0]    i_hold;
    logic [CHAR_SIZE-1:0]    q_hold;

    logic signed [DATA_SIZE-1:0] i_shift;
    logic signed [DATA_SIZE-1:0] q_shift;
    logic [CHAR_SIZE-1:0]    i_deq;
    logic [CHAR_SIZE-1:0]    q_deq;
    logic                    i_sat;
    logic                    q_sat;
    logic                    load;
    logic [16:0]             sat_sum;
    logic [15:0]             sat_next;

    // Arithmetic shift floors toward negative infinity; no rounding is applied.
    assign i_shift = $signed(i_in_dout) >>> BITS;
    assign q_shift = $signed(q_in_dout) >>> BITS;

    always_comb begin
        i_sat = 1'b1;
        q_sat = 1'b1;
        if (i_shift > SAT_MAX) begin
            i_deq = SAT_MAX[CHAR_SIZE-1:0];
        end else if (i_shift < SAT_MIN) begin
            i_deq = SAT_MIN[CHAR_SIZE-1:0];
        end else begin
            i_deq = i_shift[CHAR_SIZE-1:0];
            i_sat = 1'b0;
        end
        if (q_shift > SAT_MAX) begin
            q_deq = SAT_MAX[CHAR_SIZE-1:0];
        end else if (q_shift < SAT_MIN) begin
            q_deq = SAT_MIN[CHAR_SIZE-1:0];
        end else begin
            q_deq = q_shift[CHAR_SIZE-1:0];
            q_sat = 1'b0;
        end
    end

    assign sat_sum  = {1'b0, sat_count} + 17'(i_sat) + 17'(q_sat);
    assign sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

    // Reset gates the strobes so nothing is popped or written on the reset edge itself.
    assign load = ((state == S_LOAD) || ((state == S_EMIT) && (idx == 2'd3) && !out_full))
                  && !i_in_empty && !q_in_empty && !reset;

    assign i_in_rd_en = load;
    assign q_in_rd_en = load;
    assign out_wr_en  = (state == S_EMIT) && !out_full && !reset;
    assign fsm_state  = state;

    always_comb begin
        out_din = '0;
        if (state == S_EMIT) begin
            case (idx)
                2'd0:    out_din = i_hold[BYTE_SIZE-1:0];
                2'd1:    out_din = i_hold[2*BYTE_SIZE-1:BYTE_SIZE];
                2'd2:    out_din = q_hold[BYTE_SIZE-1:0];
                default: out_din = q_hold[2*BYTE_SIZE-1:BYTE_SIZE];
            endcase
        end
    end

    // A load in S_EMIT coincides with the idx==3 write, so the later capture wins cleanly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_LOAD;
            idx        <= 2'd0;
            i_hold     <= '0;
            q_hold     <= '0;
            pair_count <= 32'd0;
            sat_count  <= 16'd0;
        end else begin
            if (out_wr_en) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    pair_count <= pair_count + 32'd1;
                    state      <= S_LOAD;
                end
            end
            if (load) begin
                i_hold    <= i_deq;
                q_hold    <= q_deq;
                idx       <= 2'd0;
                state     <= S_EMIT;
                sat_count <= sat_next;
            end
        end
    end

endmodule

// File: doc/write_iq.md
Name: write_iq

Overview:
- Output-side serializer, the inverse of the read_iq input stage.
- Pops paired 32-bit fixed-point I and Q samples from two show-ahead FIFOs, dequantizes by arithmetic right shift of BITS, saturates to signed 16-bit, and emits little-endian bytes in the order I_lo, I_hi, Q_lo, Q_hi into a byte FIFO.
- Sits at the tail of the FM radio chain, or in a loopback bench behind read_iq_top, so the byte stream can be compared against the original file.

Parameters:
- DATA_SIZE, 32, width of I/Q input samples.
- BYTE_SIZE, 8, width of output byte.
- CHAR_SIZE, 16, width of serialized sample (two bytes).
- BITS, 10, fractional bits removed by dequantization.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset (one clock; reset sampled on rising edge of clock).
- i_in_empty  in  1  I FIFO empty.
- i_in_rd_en  out  1  I FIFO pop.
- i_in_dout  in  DATA_SIZE  I sample, signed; valid whenever !i_in_empty (show-ahead).
- q_in_empty  in  1  Q FIFO empty.
- q_in_rd_en  out  1  Q FIFO pop.
- q_in_dout  in  DATA_SIZE  Q sample, signed, show-ahead.
- out_full  in  1  byte FIFO full.
- out_wr_en  out  1  byte FIFO write.
- out_din  out  BYTE_SIZE  byte to write.
- pair_count  out  32  number of I/Q pairs fully emitted; wraps modulo 2^32.
- sat_count  out  16  number of 16-bit components that saturated; holds at 0xFFFF.

Behaviour:
- State registers:
  - state in {S_LOAD, S_EMIT}.
  - idx[1:0] selects the byte being emitted.
  - i_hold[15:0] and q_hold[15:0] hold the current pair.
  - pair_count and sat_count.
- Reset:
  - state=S_LOAD, idx=0, holds=0, counters=0.
  - Hence i_in_rd_en=q_in_rd_en=out_wr_en=0 and out_din=0x00.
  - Reset mid-pair discards the held pair; bytes already written stay written; nothing further is popped or written during reset.
- Combinational outputs:
  - load = (state==S_LOAD || (state==S_EMIT && idx==3 && !out_full)) && !i_in_empty && !q_in_empty.
  - i_in_rd_en = q_in_rd_en = load. Both FIFOs always pop together.
  - out_wr_en = (state==S_EMIT) && !out_full.
  - out_din is selected by idx: 0 gives i_hold[7:0], 1 gives i_hold[15:8], 2 gives q_hold[7:0], 3 gives q_hold[15:8].
  - out_din=0 in S_LOAD.
- Dequantize:
  - d = din >>> BITS, arithmetic shift, floor toward negative infinity, no rounding.
  - Saturate: d > 32767 gives 0x7FFF; d < -32768 gives 0x8000; otherwise d[15:0].
  - Each saturated component adds 1 to sat_count on the load edge (0, 1 or 2 per pair), saturating at 0xFFFF.
- S_LOAD: on load, capture the dequantized I/Q into the holds, set idx=0, go to S_EMIT. Otherwise stay.
- S_EMIT:
  - When out_wr_en is asserted, idx increments.
  - When idx==3 and a write occurs, pair_count increments.
  - Then, if load is asserted the same cycle, the next pair is captured, idx=0 and the state stays S_EMIT (back-to-back); otherwise go to S_LOAD.
  - When out_full=1, hold idx and the holds; no byte is dropped or duplicated.
- One side empty (only I or only Q available): no pop, stays or returns to S_LOAD.
- Latency: the first byte is written the cycle after the pop.
- Throughput: 4 cycles per pair sustained, 1 byte per cycle.

Test Plan:
- Basic: I=0x00000400, Q=0xFFFFFC00, out_full=0.
  - Bytes 01,00,FF,FF on 4 consecutive cycles, starting 1 cycle after the pop.
  - pair_count=1, sat_count=0.
- Saturation: I=0x7FFFFFFF, Q=0x80000000.
  - Bytes FF,7F,00,80; sat_count=2.
- Truncation: I=0x000007FF, Q=0xFFFFFFFF.
  - Bytes 01,00,FF,FF (floor semantics).
- Backpressure and streaming: 3 pairs preloaded; out_full forced high for 3 cycles after byte 1 of pair 2.
  - Exactly 12 bytes, in order.
  - Rd_en pulses exactly 3 times, back-to-back with no idle cycle except during the stall.
- Unbalanced and reset: I FIFO non-empty, Q empty for 10 cycles gives no rd_en and no wr_en. Then Q is filled and reset is asserted after byte 2.
  - All outputs 0 on the next cycle.
  - Counters 0.
  - Next pair emits starting at byte 0.
- Loopback: 32000 bytes of usrp.dat through read_iq_top (BITS=10) into write_iq.
  - 32000 output bytes identical to the input file.
  - pair_count=8000, sat_count=0.
